// File: rtl/display_pkg.sv
// Shared definitions for the binary-to-BCD display front end.
package display_pkg;

   // Conversion engine states
   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_CONVERT = 1'b1
   } conv_state_e;

   // Level of an anode line when its digit is dark (common-anode, active low)
   localparam logic ANODE_OFF = 1'b1;

   // Packed BCD width needed to hold 2^bin_w - 1
   function automatic int unsigned bcd_width(input int unsigned bin_w);
      longint unsigned v;
      int unsigned     d;
      v = (bin_w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bin_w) - 64'd1);
      d = 0;
      for (int i = 0; i < 20; i++) begin
         if (v != 64'd0) begin
            d = d + 1;
            v = v / 64'd10;
         end
      end
      if (d == 0) d = 1;
      return 4 * d;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Multi-cycle double-dabble engine: one input bit per cycle, DATA_WIDTH cycles.
// done_c_o/bcd_c_o are combinational so the caller can register the result on
// the same edge the engine returns to idle.
module bin2bcd_seq
   import display_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BCD_W      = bcd_width(DATA_WIDTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  busy_o,
   output logic                  done_c_o,
   output logic [BCD_W-1:0]      bcd_c_o
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
   localparam int unsigned N_NIB = BCD_W / 4;

   conv_state_e           state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] sr_q, sr_d;
   logic [BCD_W-1:0]      acc_q, acc_d;
   logic [BCD_W-1:0]      adj_c, shift_c;

   // Add-3 correction on every nibble >= 5, then shift the next input bit in
   always_comb begin
      adj_c = acc_q;
      for (int i = 0; i < int'(N_NIB); i++) begin
         if (adj_c[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = adj_c[4*i +: 4] + 4'd3;
      end
      shift_c = BCD_W'({adj_c, sr_q[DATA_WIDTH-1]});
   end

   // Next-state and datapath control
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      acc_d    = acc_q;
      done_c_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_i) begin
               state_d = ST_CONVERT;
               sr_d    = data_i;
               acc_d   = '0;
               cnt_d   = CNT_W'(DATA_WIDTH);
            end
         end
         ST_CONVERT: begin
            acc_d = shift_c;
            sr_d  = sr_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d  = ST_IDLE;
               done_c_o = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Engine state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         acc_q   <= acc_d;
      end
   end

   assign busy_o  = (state_q == ST_CONVERT);
   assign bcd_c_o = shift_c;

endmodule

// File: rtl/bin_to_bcd_scan.sv
// 7-segment front end: signed/unsigned capture, sequential BCD conversion and
// multiplexed digit scan with active-low anode strobes.
// Optional macro LEADING_ZERO_BLANK_EN: blank digits above the most
// significant non-zero digit (digit 0 is always shown).
module bin_to_bcd_scan
   import display_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned N_DIGITS    = 4,
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_signed,
   input  logic                  i_load,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_neg,
   output logic [3:0]            o_bcd,
   output logic                  o_digit_en,
   output logic [N_DIGITS-1:0]   o_anode
);

   localparam int unsigned BCD_W = bcd_width(DATA_WIDTH);
   localparam int unsigned DIG_W = 4 * N_DIGITS;
   localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int unsigned PRE_W = $clog2(REFRESH_DIV);

   if (DIG_W < BCD_W) begin : g_bad_digits
      $error("N_DIGITS too small for DATA_WIDTH");
   end
   if (REFRESH_DIV < 2) begin : g_bad_div
      $error("REFRESH_DIV must be at least 2");
   end

   logic                  busy;
   logic                  done_c;
   logic [BCD_W-1:0]      bcd_c;
   logic                  neg_c;
   logic                  accept_c;
   logic [DATA_WIDTH-1:0] mag_c;

   logic                         sign_q, sign_d;
   logic                         neg_q, neg_d;
   logic                         done_q, done_d;
   logic [N_DIGITS-1:0][3:0]     digits_q, digits_d;
   logic [PRE_W-1:0]             pre_q, pre_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [N_DIGITS-1:0]          anode_q, anode_d;
   logic [3:0]                   bcd_q, bcd_d;
   logic                         en_q, en_d;

   // Sign detection and magnitude (most-negative value maps to 2^(W-1))
   always_comb begin
      neg_c    = i_signed & i_data[DATA_WIDTH-1];
      mag_c    = neg_c ? (~i_data + DATA_WIDTH'(1)) : i_data;
      accept_c = i_load & ~busy;
   end

   bin2bcd_seq #(
      .DATA_WIDTH (DATA_WIDTH),
      .BCD_W      (BCD_W)
   ) u_engine (
      .clk_i    (i_clk),
      .rst_ni   (i_rst_n),
      .load_i   (i_load),
      .data_i   (mag_c),
      .busy_o   (busy),
      .done_c_o (done_c),
      .bcd_c_o  (bcd_c)
   );

   // Latch sign at capture; publish digits and sign together at completion
   always_comb begin
      sign_d   = sign_q;
      neg_d    = neg_q;
      digits_d = digits_q;
      done_d   = done_c;
      if (accept_c) sign_d = neg_c;
      if (done_c) begin
         digits_d = DIG_W'(bcd_c);
         neg_d    = sign_q;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [N_DIGITS-1:0] lz_en_c;
   logic                seen_c;

   // Enable a digit if it or any more significant digit is non-zero
   always_comb begin
      seen_c  = 1'b0;
      lz_en_c = '0;
      for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
         seen_c     = seen_c | (digits_q[i] != 4'd0);
         lz_en_c[i] = seen_c | (i == 0);
      end
   end
`endif

   // Free-running prescaler, scan index and registered scan outputs
   always_comb begin
      idx_d = idx_q;
      if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
         pre_d = '0;
         idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end else begin
         pre_d = pre_q + PRE_W'(1);
      end
      anode_d = ~(N_DIGITS'(1) << idx_q);
      bcd_d   = digits_q[idx_q];
`ifdef LEADING_ZERO_BLANK_EN
      en_d    = lz_en_c[idx_q];
`else
      en_d    = 1'b1;
`endif
   end

   // Top-level state registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sign_q   <= 1'b0;
         neg_q    <= 1'b0;
         done_q   <= 1'b0;
         digits_q <= '0;
         pre_q    <= '0;
         idx_q    <= '0;
         anode_q  <= {N_DIGITS{ANODE_OFF}};
         bcd_q    <= '0;
         en_q     <= 1'b0;
      end else begin
         sign_q   <= sign_d;
         neg_q    <= neg_d;
         done_q   <= done_d;
         digits_q <= digits_d;
         pre_q    <= pre_d;
         idx_q    <= idx_d;
         anode_q  <= anode_d;
         bcd_q    <= bcd_d;
         en_q     <= en_d;
      end
   end

   assign o_busy     = busy;
   assign o_done     = done_q;
   assign o_neg      = neg_q;
   assign o_bcd      = bcd_q;
   assign o_digit_en = en_q;
   assign o_anode    = anode_q;

endmodule

// File: tb/tb_bin_to_bcd_scan.sv
// Directed self-checking bench for bin_to_bcd_scan (REFRESH_DIV = 4).
module tb_bin_to_bcd_scan;

   logic       clk;
   logic       rst_n;
   logic [7:0] i_data;
   logic       i_signed;
   logic       i_load;
   logic       o_busy;
   logic       o_done;
   logic       o_neg;
   logic [3:0] o_bcd;
   logic       o_digit_en;
   logic [3:0] o_anode;

   int n_checks = 0;
   int n_fail   = 0;

   bin_to_bcd_scan #(
      .DATA_WIDTH  (8),
      .N_DIGITS    (4),
      .REFRESH_DIV (4)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_data     (i_data),
      .i_signed   (i_signed),
      .i_load     (i_load),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_neg      (o_neg),
      .o_bcd      (o_bcd),
      .o_digit_en (o_digit_en),
      .o_anode    (o_anode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected digit-enable mask for a displayed value
   function automatic logic [3:0] exp_en(input logic [15:0] v);
      logic [3:0] m;
      logic       seen;
      m    = 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
      seen = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         seen = seen | (v[4*i +: 4] != 4'd0);
         m[i] = seen | (i == 0);
      end
`else
      seen = |v;
      if (seen) m = 4'hF;
`endif
      return m;
   endfunction

   // Observe one full scan (16 cycles) and collect digits/enables per slot
   task automatic read_display(output logic [15:0] disp, output logic [3:0] en,
                               output logic onehot_ok);
      disp = '0;
      en = '0;
      onehot_ok = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if ($countones(~o_anode) != 1) onehot_ok = 1'b0;
         for (int d = 0; d < 4; d++) begin
            if (!o_anode[d]) begin
               disp[4*d +: 4] = o_bcd;
               en[d] = o_digit_en;
            end
         end
      end
   endtask

   task automatic check_display(input string name, input logic [15:0] exp_disp,
                                input logic exp_neg);
      logic [15:0] disp;
      logic [3:0]  en;
      logic        ok;
      read_display(disp, en, ok);
      n_checks++;
      if (disp !== exp_disp) begin
         n_fail++;
         $display("FAIL %s digits got=%h exp=%h", name, disp, exp_disp);
      end
      n_checks++;
      if (en !== exp_en(exp_disp)) begin
         n_fail++;
         $display("FAIL %s digit_en got=%b exp=%b", name, en, exp_en(exp_disp));
      end
      n_checks++;
      if (ok !== 1'b1) begin
         n_fail++;
         $display("FAIL %s anode_onehot got=0 exp=1", name);
      end
      n_checks++;
      if (o_neg !== exp_neg) begin
         n_fail++;
         $display("FAIL %s neg got=%b exp=%b", name, o_neg, exp_neg);
      end
   endtask

   task automatic test_reset();
      logic [3:0] sh;
      rst_n = 1'b0;
      i_load = 1'b0;
      i_data = '0;
      i_signed = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({o_busy, o_done, o_neg, o_digit_en} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags got=%b exp=0000", {o_busy, o_done, o_neg, o_digit_en});
      end
      n_checks++;
      if (o_bcd !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_bcd got=%h exp=0", o_bcd);
      end
      n_checks++;
      if (o_anode !== 4'b1111) begin
         n_fail++;
         $display("FAIL reset_anode got=%b exp=1111", o_anode);
      end
      rst_n = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         sh = 4'b0001 << ((c - 1) / 4);
         n_checks++;
         if (o_anode !== ~sh) begin
            n_fail++;
            $display("FAIL scan_anode cycle=%0d got=%b exp=%b", c, o_anode, ~sh);
         end
         n_checks++;
         if (o_bcd !== 4'd0 || o_neg !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_zero cycle=%0d bcd=%h neg=%b exp 0/0", c, o_bcd, o_neg);
         end
      end
   endtask

   // One conversion with cycle-exact busy/done checks, then a display readback
   task automatic test_convert(input string name, input logic [7:0] d, input logic s,
                               input logic [15:0] exp_disp, input logic exp_neg);
      logic exp_busy, exp_done;
      logic [3:0] exp_dig;
      @(negedge clk);
      i_data = d;
      i_signed = s;
      i_load = 1'b1;
      @(negedge clk);
      i_load = 1'b0;
      for (int c = 0; c <= 9; c++) begin
         if (c > 0) @(negedge clk);
         exp_busy = (c < 8);
         exp_done = (c == 8);
         n_checks++;
         if (o_busy !== exp_busy || o_done !== exp_done) begin
            n_fail++;
            $display("FAIL %s busy/done cycle=%0d got=%b%b exp=%b%b",
                     name, c, o_busy, o_done, exp_busy, exp_done);
         end
         if (c == 8) begin
            n_checks++;
            if (o_neg !== exp_neg) begin
               n_fail++;
               $display("FAIL %s neg_at_done got=%b exp=%b", name, o_neg, exp_neg);
            end
         end
         if (c == 9) begin
            exp_dig = 4'hx;
            for (int k = 0; k < 4; k++) if (!o_anode[k]) exp_dig = exp_disp[4*k +: 4];
            n_checks++;
            if (o_bcd !== exp_dig) begin
               n_fail++;
               $display("FAIL %s bcd_next_cycle got=%h exp=%h", name, o_bcd, exp_dig);
            end
         end
      end
      check_display(name, exp_disp, exp_neg);
   endtask

   task automatic test_ignore_busy();
      int dones, busy_after;
      @(negedge clk);
      i_data = 8'd42;
      i_signed = 1'b0;
      i_load = 1'b1;
      @(negedge clk);
      i_load = 1'b0;
      repeat (2) @(negedge clk);
      i_data = 8'd99;
      i_load = 1'b1;
      @(negedge clk);
      i_load = 1'b0;
      dones = 0;
      busy_after = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (dones > 0 && o_busy) busy_after++;
         if (o_done) dones++;
      end
      n_checks++;
      if (dones !== 1) begin
         n_fail++;
         $display("FAIL ignore_busy done_pulses got=%0d exp=1", dones);
      end
      n_checks++;
      if (busy_after !== 0) begin
         n_fail++;
         $display("FAIL ignore_busy queued_busy got=%0d exp=0", busy_after);
      end
      check_display("ignore_busy", 16'h0042, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic exp_busy, exp_done;
      @(negedge clk);
      i_data = 8'd5;
      i_signed = 1'b0;
      i_load = 1'b1;
      for (int c = 0; c <= 17; c++) begin
         @(negedge clk);
         if (c == 0) i_data = 8'd9;
         if (c == 9) i_load = 1'b0;
         exp_busy = (c != 8) && (c != 17);
         exp_done = (c == 8) || (c == 17);
         n_checks++;
         if (o_busy !== exp_busy || o_done !== exp_done) begin
            n_fail++;
            $display("FAIL back_to_back busy/done cycle=%0d got=%b%b exp=%b%b",
                     c, o_busy, o_done, exp_busy, exp_done);
         end
      end
      check_display("back_to_back", 16'h0009, 1'b0);
   endtask

   task automatic test_reset_mid();
      int dones, busies;
      @(negedge clk);
      i_data = 8'd200;
      i_signed = 1'b0;
      i_load = 1'b1;
      @(negedge clk);
      i_load = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({o_busy, o_done, o_neg, o_digit_en, o_bcd, o_anode} !== 12'b0000_0000_1111) begin
         n_fail++;
         $display("FAIL reset_mid outputs got=%b exp=000000001111",
                  {o_busy, o_done, o_neg, o_digit_en, o_bcd, o_anode});
      end
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      busies = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (o_done) dones++;
         if (o_busy) busies++;
      end
      n_checks++;
      if (dones !== 0 || busies !== 0) begin
         n_fail++;
         $display("FAIL reset_mid activity done=%0d busy=%0d exp 0/0", dones, busies);
      end
      check_display("reset_mid", 16'h0000, 1'b0);
   endtask

   initial begin
      test_reset();
      test_convert("u255", 8'd255, 1'b0, 16'h0255, 1'b0);
      test_convert("s80", 8'h80, 1'b1, 16'h0128, 1'b1);
      test_convert("sFF", 8'hFF, 1'b1, 16'h0001, 1'b1);
      test_convert("u80", 8'h80, 1'b0, 16'h0128, 1'b0);
      test_convert("s9C", 8'h9C, 1'b1, 16'h0100, 1'b1);
      test_convert("u7", 8'd7, 1'b0, 16'h0007, 1'b0);
      test_convert("u0", 8'd0, 1'b0, 16'h0000, 1'b0);
      test_convert("u63", 8'd63, 1'b0, 16'h0063, 1'b0);
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
